pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of flush cycles per accepted exception (legal range 1..15).
REQ-002 SHALL have parameter STALL_LIMIT, default 64, consecutive-stall count that raises the timeout pulse (legal range 2..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port stallreq_id  input  1  decode-stage stall request (operand/load-use interlock).
REQ-006 SHALL have port stallreq_ex  input  1  execute-stage stall request (multi-cycle op busy).
REQ-007 SHALL have port excp_req  input  1  exception/redirect request, held until excp_ack.
REQ-008 SHALL have port excp_pc  input  32  redirect target, valid while excp_req=1.
REQ-009 SHALL have port excp_ack  output  1  one-cycle acceptance of excp_req.
REQ-010 SHALL have port stall  output  6  per-stage hold, bit0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb.
REQ-011 SHALL have port flush  output  1  squash all in-flight pipeline registers.
REQ-012 SHALL have port new_pc  output  32  registered redirect target.
REQ-013 SHALL have port new_pc_vld  output  1  one-cycle strobe: load new_pc into pc.
REQ-014 SHALL have port stall_timeout  output  1  one-cycle pulse on stall watchdog expiry.

Function
REQ-015 SHALL implement FSM states RUN, FLUSH; accept cycle is RUN with excp_req=1.
REQ-016 RUN, excp_req=0: stall SHALL be 6'b001111 if stallreq_ex=1, else 6'b000111 if stallreq_id=1, else 6'b000000 (combinational, same cycle).
REQ-017 RUN, excp_req=1: excp_ack=1 and stall=6'b111111 SHALL hold that cycle regardless of stall requests; excp_pc captured into new_pc; next state FLUSH.
REQ-018 FLUSH SHALL last exactly FLUSH_CYCLES cycles with flush=1, stall=0, excp_ack=0; then RUN.
REQ-019 new_pc_vld SHALL be 1 only in the first FLUSH cycle; new_pc SHALL hold its value until the next accept.
REQ-020 excp_req and stall requests during FLUSH SHALL be ignored (no ack, no stall); a still-held excp_req SHALL be accepted in the first RUN cycle after FLUSH.
REQ-021 Exception acceptance SHALL take priority over stallreq_ex, which takes priority over stallreq_id.
REQ-022 An 8-bit stall counter SHALL increment each RUN cycle with stall[0]=1 and excp_req=0, clear on any other cycle, and saturate at STALL_LIMIT.
REQ-023 stall_timeout SHALL pulse for exactly one cycle, the cycle the counter transitions from STALL_LIMIT-1 to STALL_LIMIT; no repeat until the counter clears and re-reaches the limit.
REQ-024 Watchdog SHALL not alter stall; it is report-only.
REQ-025 excp_ack SHALL never assert on two consecutive cycles.

Reset
REQ-026 While rst=1 all outputs SHALL be 0 (stall=0, flush=0, new_pc=0, new_pc_vld=0, excp_ack=0, stall_timeout=0) regardless of inputs, state=RUN, stall counter=0.
REQ-027 rst asserted mid-FLUSH SHALL abort the flush immediately; after release the block SHALL be in RUN with no pending strobe.

Verification
REQ-028 stallreq_id=1 for 3 cycles, then stallreq_ex=1 with stallreq_id=1 -> stall=000111 x3, then 001111; no ack, no flush.
REQ-029 excp_req=1, excp_pc=0xBFC00380 in RUN -> cycle N: excp_ack=1, stall=111111; N+1: flush=1, new_pc_vld=1, new_pc=0xBFC00380; N+2: flush=1, new_pc_vld=0; N+3: RUN, flush=0.
REQ-030 excp_req held through FLUSH with stallreq_ex=1 -> stall=0 during FLUSH, second excp_ack in first RUN cycle after FLUSH.
REQ-031 stallreq_ex=1 for 70 cycles (STALL_LIMIT=64) -> stall_timeout=1 only on the 64th stall cycle; stall stays 001111 throughout; drop and re-raise for 64 -> second pulse.
REQ-032 rst asserted asynchronously during first FLUSH cycle -> all outputs 0 before next clk edge; after release with excp_req=0 -> stall=0, flush=0, no new_pc_vld.
REQ-033 excp_req=1 on same cycle as stallreq_ex=1 with counter at 63 -> excp_ack=1, stall=111111, no stall_timeout, counter cleared.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall, exception flush/redirect,
// and a report-only watchdog on long runs of consecutive stalls.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_LIMIT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        excp_req,
    input  logic [31:0] excp_pc,
    output logic        excp_ack,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        new_pc_vld,
    output logic        stall_timeout
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] STALL_MAX  = 8'(STALL_LIMIT);
    localparam logic [7:0] STALL_PRE  = 8'(STALL_LIMIT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] flush_cnt;
    logic [7:0] stall_cnt;
    logic       stall_cnt_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (excp_req) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        excp_ack      = 1'b0;
        stall         = 6'b000000;
        flush         = 1'b0;
        stall_cnt_en  = 1'b0;
        stall_timeout = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (excp_req) begin
                        excp_ack = 1'b1;
                        stall    = 6'b111111;
                    end else if (stallreq_ex) begin
                        stall = 6'b001111;
                    end else if (stallreq_id) begin
                        stall = 6'b000111;
                    end
                    // counter only runs on plain stall cycles, never on accept
                    stall_cnt_en  = stall[0] & ~excp_req;
                    stall_timeout = stall_cnt_en & (stall_cnt == STALL_PRE);
                end
                FLUSH:   flush = 1'b1;
                default: flush = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flush_cnt <= 4'd0;
        else if (state == RUN) flush_cnt <= 4'd0;
        else flush_cnt <= flush_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_pc     <= 32'd0;
            new_pc_vld <= 1'b0;
        end else begin
            new_pc_vld <= excp_ack;
            if (excp_ack) new_pc <= excp_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt <= 8'd0;
        else if (!stall_cnt_en) stall_cnt <= 8'd0;
        else if (stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 8'd1;
    end

endmodule
